// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the byte-serial wide adder.
// Holds the FSM encoding and the 4-bit carry-lookahead function used by the byte adder.
package serial_adder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // 4-bit carry-lookahead add: returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], p ^ c[3:0]};
  endfunction

endpackage

// File: rtl/C_Select_adder_with_CLA_block_8bit.sv
// 8-bit carry-select adder built from 4-bit carry-lookahead blocks.
// The upper nibble is computed for both carry-in values and selected by the lower nibble's carry.
module C_Select_adder_with_CLA_block_8bit
  import serial_adder_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [4:0] lo;
  logic [4:0] hi0;
  logic [4:0] hi1;
  logic [4:0] hi;

  always_comb begin
    lo   = cla4(a[3:0], b[3:0], cin);
    hi0  = cla4(a[7:4], b[7:4], 1'b0);
    hi1  = cla4(a[7:4], b[7:4], 1'b1);
    hi   = lo[4] ? hi1 : hi0;
    sum  = {hi[3:0], lo[3:0]};
    cout = hi[4];
  end

endmodule

// File: rtl/byte_lane_select.sv
// Picks byte lane cnt of the captured operands for the byte adder.
// With SUBTRACT_EN defined, the selected b byte is inverted when sub is set.
module byte_lane_select
  import serial_adder_pkg::*;
#(
  parameter int NBYTES = 4,
  parameter int CW     = 2
) (
  input  logic [BYTE_W*NBYTES-1:0] word_a,
  input  logic [BYTE_W*NBYTES-1:0] word_b,
  input  logic [CW-1:0]            cnt,
`ifdef SUBTRACT_EN
  input  logic                     sub,
`endif
  output logic [BYTE_W-1:0]        byte_a,
  output logic [BYTE_W-1:0]        byte_b
);

  logic [BYTE_W-1:0] raw_b;

  always_comb begin
    byte_a = '0;
    raw_b  = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (cnt == CW'(i)) begin
        byte_a = word_a[i*BYTE_W +: BYTE_W];
        raw_b  = word_b[i*BYTE_W +: BYTE_W];
      end
    end
`ifdef SUBTRACT_EN
    byte_b = sub ? ~raw_b : raw_b;
`else
    byte_b = raw_b;
`endif
  end

endmodule

// File: rtl/serial_wide_adder_8.sv
// Byte-serial wide adder: feeds one byte pair per cycle (LSB first) through an 8-bit adder.
// Optional SUBTRACT_EN adds a sub input that turns the operation into a-b.
module serial_wide_adder_8
  import serial_adder_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  cin,
`ifdef SUBTRACT_EN
  input  logic                  sub,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout,
  output logic                  busy
);

  localparam int WIDTH = BYTE_W * NBYTES;
  localparam int CW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE and out_valid only in DONE, each derived from state alone.
  state_t            state_q;
  state_t            state_d;
  logic [CW-1:0]     cnt_q;
  logic              carry_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;
`ifdef SUBTRACT_EN
  logic              sub_q;
`endif

  logic [BYTE_W-1:0] lane_a;
  logic [BYTE_W-1:0] lane_b;
  logic [BYTE_W-1:0] add_sum;
  logic              add_cout;
  logic              last;

  assign last = (cnt_q == CW'(NBYTES - 1));

  byte_lane_select #(
    .NBYTES (NBYTES),
    .CW     (CW)
  ) u_lane (
    .word_a (a_q),
    .word_b (b_q),
    .cnt    (cnt_q),
`ifdef SUBTRACT_EN
    .sub    (sub_q),
`endif
    .byte_a (lane_a),
    .byte_b (lane_b)
  );

  C_Select_adder_with_CLA_block_8bit u_adder (
    .a    (lane_a),
    .b    (lane_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

  // Carry between bytes lives only in carry_q, so a/b never reach sum combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SUBTRACT_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            cnt_q <= '0;
`ifdef SUBTRACT_EN
            sub_q   <= sub;
            carry_q <= sub ? 1'b1 : cin;
`else
            carry_q <= cin;
`endif
          end
        end
        RUN: begin
          for (int i = 0; i < NBYTES; i++) begin
            if (cnt_q == CW'(i)) sum_q[i*BYTE_W +: BYTE_W] <= add_sum;
          end
          carry_q <= add_cout;
          cnt_q   <= cnt_q + CW'(1);
          if (last) cout_q <= add_cout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_wide_adder_8.sv
// Directed-vector bench for serial_wide_adder_8 (NBYTES=4); subtract vectors run when SUBTRACT_EN is defined.
module tb_serial_wide_adder_8;

  localparam int NBYTES = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        busy;

  logic [32:0] exp_q[$];
  int          n_checks;
  int          n_fail;

  serial_wide_adder_8 #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SUBTRACT_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one operation, waits for the result, optionally stalls in DONE, then drains it.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc,
                        input logic ts, input logic [31:0] es, input logic ec,
                        input int hold, input string tag);
    logic [32:0] exp_word;
    int          cyc;
    exp_q.push_back({ec, es});
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = ~tc;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(NBYTES));
    exp_word = exp_q.pop_front();
    check({tag, "_sum"}, 64'(sum), 64'(exp_word[31:0]));
    check({tag, "_cout"}, 64'(cout), 64'(exp_word[32]));
    check({tag, "_busy"}, 64'(busy), 64'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = $urandom; b = $urandom;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({tag, "_hold_sum"}, 64'(sum), 64'(exp_word[31:0]));
      check({tag, "_hold_cout"}, 64'(cout), 64'(exp_word[32]));
      check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_drain_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_drain_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_idle_sum"}, 64'(sum), 64'(exp_word[31:0]));
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    #12;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_sum", 64'(sum), 64'd0);
    check("reset_cout", 64'(cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 0, "byte_carry");
    run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 0, "ripple_all");
    run_op(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 0, "msb_over");
    run_op(32'd200, 32'd20, 1'b0, 1'b0, 32'd220, 1'b0, 0, "small");
    run_op(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'hACF13568, 1'b0, 0, "mixed");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 5, "stall");

    // asynchronous reset with cnt=2
    @(negedge clk);
    a = 32'h11111111; b = 32'h22222222; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    check("midrun_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_in_ready", 64'(in_ready), 64'd1);
    check("async_busy", 64'(busy), 64'd0);
    check("async_sum", 64'(sum), 64'd0);
    check("async_cout", 64'(cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd2, 32'd5, 1'b0, 1'b0, 32'd7, 1'b0, 0, "after_reset");

`ifdef SUBTRACT_EN
    run_op(32'd7, 32'd5, 1'b0, 1'b1, 32'd2, 1'b1, 0, "sub_pos");
    run_op(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 0, "sub_neg");
    run_op(32'd7, 32'd5, 1'b1, 1'b1, 32'd2, 1'b1, 0, "sub_cin_ign");
    run_op(32'd7, 32'd5, 1'b1, 1'b0, 32'd13, 1'b0, 0, "sub_off_add");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
